multiport_register_file: RTL

MULTIPORT_REGISTER_FILE -- requirements
Module: multiport_register_file

---
 rtl/multiport_register_file.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/multiport_register_file.sv
// Multiport register file with a self-clearing sweep, a per-register pending-write
// scoreboard, combinational write bypass on every read port and a handshaked debug port.
module multiport_register_file #(
  parameter int unsigned ADDRESS_WIDTH  = 5,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_READ_PORTS = 2,
  parameter bit          ZERO_REG       = 1'b1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  // core write port
  input  logic                                     write_en,
  input  logic [ADDRESS_WIDTH-1:0]                 write_id,
  input  logic [DATA_WIDTH-1:0]                    write_data,
  // read ports, port i occupies slice i
  input  logic [NUM_READ_PORTS*ADDRESS_WIDTH-1:0]  read_id,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]     read_data,
  output logic [NUM_READ_PORTS-1:0]                read_busy,
  // scoreboard allocation
  input  logic                                     alloc_en,
  input  logic [ADDRESS_WIDTH-1:0]                 alloc_id,
  // clear control
  input  logic                                     clear_req,
  output logic                                     ready,
  // debug port
  input  logic                                     dbg_valid,
  input  logic                                     dbg_we,
  input  logic [ADDRESS_WIDTH-1:0]                 dbg_id,
  input  logic [DATA_WIDTH-1:0]                    dbg_wdata,
  output logic                                     dbg_ready,
  output logic                                     dbg_rvalid,
  output logic [DATA_WIDTH-1:0]                    dbg_rdata
);

  localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ID = ADDRESS_WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                    r_state;
  logic [ADDRESS_WIDTH-1:0]  r_sweep;
  logic                      r_ready;
  logic [DEPTH-1:0]          r_busy;
  logic                      r_dbg_rvalid;
  logic [DATA_WIDTH-1:0]     r_dbg_rdata;
  logic [DATA_WIDTH-1:0]     r_mem [DEPTH];

  logic                      w_run;
  logic                      w_wr_zero;
  logic                      w_wr_ok;
  logic                      w_dbg_xfer;
  logic                      w_dbg_wr_ok;
  logic                      w_dbg_rd;
  logic                      w_dbg_zero;
  logic [DEPTH-1:0]          w_busy_next;

  assign w_run       = (r_state == ST_RUN);
  assign w_wr_zero   = ZERO_REG && (write_id == '0);
  assign w_wr_ok     = w_run && write_en && !w_wr_zero;
  // Debug transfers only slip into cycles the core write port leaves idle.
  assign w_dbg_xfer  = w_run && dbg_valid && !write_en;
  assign w_dbg_zero  = ZERO_REG && (dbg_id == '0);
  assign w_dbg_wr_ok = w_dbg_xfer && dbg_we && !w_dbg_zero;
  assign w_dbg_rd    = w_dbg_xfer && !dbg_we;

  assign ready      = r_ready;
  assign dbg_ready  = w_run && !write_en;
  assign dbg_rvalid = r_dbg_rvalid;
  assign dbg_rdata  = r_dbg_rdata;

  // Control FSM: sweep one register per cycle in CLEAR, serve traffic in RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_sweep <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (r_sweep == LAST_ID) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
            r_sweep <= '0;
          end else begin
            r_sweep <= r_sweep + ADDRESS_WIDTH'(1);
          end
        end
        ST_RUN: begin
          if (clear_req) begin
            r_state <= ST_CLEAR;
            r_ready <= 1'b0;
            r_sweep <= '0;
          end
        end
        default: begin
          r_state <= ST_CLEAR;
          r_ready <= 1'b0;
          r_sweep <= '0;
        end
      endcase
    end
  end

  // Storage array has no reset; the sweep is what initialises it.
  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_mem[r_sweep] <= '0;
    end else if (w_wr_ok) begin
      r_mem[write_id] <= write_data;
    end else if (w_dbg_wr_ok) begin
      r_mem[dbg_id] <= dbg_wdata;
    end
  end

  // Allocation wins over a same-cycle write so a re-issued destination stays pending.
  always_comb begin
    w_busy_next = r_busy;
    if (w_run) begin
      if (write_en) begin
        w_busy_next[write_id] = 1'b0;
      end
      if (alloc_en) begin
        w_busy_next[alloc_id] = 1'b1;
      end
    end
    if (ZERO_REG) begin
      w_busy_next[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  // Debug read data is captured from the array and held until the next debug read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dbg_rvalid <= 1'b0;
      r_dbg_rdata  <= '0;
    end else begin
      r_dbg_rvalid <= w_dbg_rd;
      if (w_dbg_rd) begin
        r_dbg_rdata <= w_dbg_zero ? '0 : r_mem[dbg_id];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_READ_PORTS; gi++) begin : g_read
    logic [ADDRESS_WIDTH-1:0] w_rid;
    logic                     w_hit;
    logic                     w_zero;

    assign w_rid  = read_id[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign w_hit  = write_en && (write_id == w_rid);
    assign w_zero = ZERO_REG && (w_rid == '0);

    assign read_data[gi*DATA_WIDTH +: DATA_WIDTH] =
      (!w_run || w_zero) ? '0 : (w_hit ? write_data : r_mem[w_rid]);
    assign read_busy[gi] = w_run && r_busy[w_rid] && !w_hit;
  end

endmodule
